// File: rtl/ddr4_avmm_tester.sv
// ddr4_avmm_tester
// Avalon-MM memory tester for the DDR4 EMIF user interface.
// A run writes pat(a) = replicated ({zero-extended a} ^ seed) to
// num_words consecutive word addresses starting at base_addr. It then
// reads the range back and checks every returned word in order.
//
// Ports:
//   mem_clk, mem_rst        EMIF user clock, synchronous active-high reset
//   cal_success             start is honoured only while calibration is good
//   start, base_addr,       run request and its parameters; the parameters
//   num_words, seed         are sampled when start is accepted
//   avm_*                   Avalon-MM master (single-word bursts)
//   busy, done, pass        run status
//   err_count               saturating mismatch count
//   first_err_addr          address of the first mismatching word
module ddr4_avmm_tester #(
    parameter int DATA_W          = 512,
    parameter int ADDR_W          = 27,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ERR_W           = 16
) (
    input  logic                  mem_clk,
    input  logic                  mem_rst,
    input  logic                  cal_success,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_words,
    input  logic [31:0]           seed,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_read,
    output logic [6:0]            avm_burstcount,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  ONE_O   = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [ERR_W-1:0]  ONE_E   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Expected word for address a: 32-bit (a ^ seed) replicated across the bus.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                              input logic [31:0] s);
        logic [31:0] w;
        w = 32'(a) ^ s;
        return {(DATA_W/32){w}};
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] num_r;
    logic [31:0]       seed_r;
    logic [ADDR_W-1:0] wr_idx_r;
    logic [ADDR_W-1:0] rd_idx_r;
    logic [ADDR_W-1:0] chk_idx_r;
    logic [OUT_W-1:0]  outstanding_r;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              rdv_s;
    logic              miss_s;
    logic [ADDR_W-1:0] rd_next_s;
    logic [OUT_W-1:0]  out_next_s;
    logic [ADDR_W-1:0] chk_addr_s;

    assign avm_byteenable = {(DATA_W/8){1'b1}};
    assign avm_burstcount = 7'd1;

    // Handshake decode, next read index / outstanding count and the compare.
    always_comb begin
        wr_acc_s   = avm_write & ~avm_waitrequest;
        rd_acc_s   = avm_read & ~avm_waitrequest;
        // Returns count only while reads can be in flight; a stray valid
        // with nothing outstanding must not underflow the counter.
        rdv_s      = avm_readdatavalid &&
                     (state_r == S_READ || state_r == S_DRAIN) &&
                     (outstanding_r != {OUT_W{1'b0}});
        chk_addr_s = base_r + chk_idx_r;
        if (rd_acc_s) begin
            rd_next_s = rd_idx_r + ONE_A;
        end else begin
            rd_next_s = rd_idx_r;
        end
        if (rd_acc_s && !rdv_s) begin
            out_next_s = outstanding_r + ONE_O;
        end else if (!rd_acc_s && rdv_s) begin
            out_next_s = outstanding_r - ONE_O;
        end else begin
            out_next_s = outstanding_r;
        end
        if (rdv_s) begin
            miss_s = (avm_readdata != pat(chk_addr_s, seed_r));
        end else begin
            miss_s = 1'b0;
        end
    end

    // Run FSM, request generation and the registered check path.
    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_r        <= S_IDLE;
            base_r         <= {ADDR_W{1'b0}};
            num_r          <= {ADDR_W{1'b0}};
            seed_r         <= 32'h0;
            wr_idx_r       <= {ADDR_W{1'b0}};
            rd_idx_r       <= {ADDR_W{1'b0}};
            chk_idx_r      <= {ADDR_W{1'b0}};
            outstanding_r  <= {OUT_W{1'b0}};
            avm_address    <= {ADDR_W{1'b0}};
            avm_write      <= 1'b0;
            avm_writedata  <= {DATA_W{1'b0}};
            avm_read       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= {ERR_W{1'b0}};
            first_err_addr <= {ADDR_W{1'b0}};
        end else begin
            outstanding_r <= out_next_s;
            if (rdv_s) begin
                chk_idx_r <= chk_idx_r + ONE_A;
            end
            if (miss_s) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ONE_E;
                end
                // err_count is still zero only until the first mismatch.
                if (err_count == {ERR_W{1'b0}}) begin
                    first_err_addr <= chk_addr_s;
                end
            end

            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start && cal_success) begin
                        base_r         <= base_addr;
                        num_r          <= num_words;
                        seed_r         <= seed;
                        wr_idx_r       <= {ADDR_W{1'b0}};
                        rd_idx_r       <= {ADDR_W{1'b0}};
                        chk_idx_r      <= {ADDR_W{1'b0}};
                        outstanding_r  <= {OUT_W{1'b0}};
                        err_count      <= {ERR_W{1'b0}};
                        first_err_addr <= {ADDR_W{1'b0}};
                        if (num_words == {ADDR_W{1'b0}}) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_r       <= S_WRITE;
                            done          <= 1'b0;
                            pass          <= 1'b0;
                            busy          <= 1'b1;
                            avm_write     <= 1'b1;
                            avm_address   <= base_addr;
                            avm_writedata <= pat(base_addr, seed);
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_acc_s) begin
                        if (wr_idx_r + ONE_A == num_r) begin
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= base_r;
                            state_r     <= S_READ;
                        end else begin
                            wr_idx_r      <= wr_idx_r + ONE_A;
                            avm_address   <= avm_address + ONE_A;
                            avm_writedata <= pat(avm_address + ONE_A, seed_r);
                        end
                    end
                end
                S_READ: begin
                    rd_idx_r <= rd_next_s;
                    if (rd_acc_s && rd_next_s == num_r) begin
                        avm_read <= 1'b0;
                        state_r  <= S_DRAIN;
                    end else begin
                        // Request stays up across a stall: an unaccepted read
                        // leaves rd_next_s and out_next_s unchanged.
                        avm_read    <= (rd_next_s < num_r) && (out_next_s < OUT_MAX);
                        avm_address <= base_r + rd_next_s;
                    end
                end
                S_DRAIN: begin
                    // Compare results land at the return edge, so err_count is
                    // final once nothing is outstanding.
                    if (outstanding_r == {OUT_W{1'b0}} && chk_idx_r == num_r) begin
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == {ERR_W{1'b0}});
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_avmm_tester.sv
// Directed testbench for ddr4_avmm_tester with a behavioural Avalon slave
// (memory, optional random waitrequest, in-order returns with latency).
module tb_ddr4_avmm_tester;

    logic         mem_clk = 1'b0;
    logic         mem_rst;
    logic         cal_success;
    logic         start;
    logic [26:0]  base_addr;
    logic [26:0]  num_words;
    logic [31:0]  seed;
    logic [26:0]  avm_address;
    logic         avm_write;
    logic [511:0] avm_writedata;
    logic [63:0]  avm_byteenable;
    logic         avm_read;
    logic [6:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [511:0] avm_readdata;
    logic         avm_readdatavalid;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  err_count;
    logic [26:0]  first_err_addr;

    ddr4_avmm_tester dut (
        .mem_clk(mem_clk), .mem_rst(mem_rst), .cal_success(cal_success),
        .start(start), .base_addr(base_addr), .num_words(num_words), .seed(seed),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 mem_clk = ~mem_clk;

    int vectors = 0;
    int miscompares = 0;

    // Slave model state
    typedef struct {
        logic [26:0] addr;
        int          due;
    } rq_t;
    rq_t          q[$];
    logic [511:0] mem[int unsigned];
    bit           corrupt[int unsigned];
    bit           wait_en = 1'b0;
    int           lat_min = 2;
    int           lat_max = 2;
    int           cyc = 0;
    int           last_due = 0;
    int           out_cnt = 0;
    int           max_out = 0;
    int           n_wr = 0;
    int           n_rd = 0;
    int           first_wr_cyc = -1;
    int           last_wr_cyc = -1;
    int           stab_err = 0;
    int           both_err = 0;
    bit           prev_stall = 1'b0;
    logic         pw, pr;
    logic [26:0]  pa;
    logic [511:0] pd;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge mem_clk);
        start = 1'b1;
        @(negedge mem_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge mem_clk);
        end
        check(tag, 512'(seen), 512'd1);
    endtask

    task automatic clear_counts();
        n_wr = 0;
        n_rd = 0;
        first_wr_cyc = -1;
        last_wr_cyc = -1;
        max_out = 0;
    endtask

    // Slave: decides inputs for the next edge shortly after each rising edge.
    initial begin
        int ws;
        int due;
        logic [511:0] rd;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(posedge mem_clk);
            #1;
            cyc++;
            if (mem_rst) begin
                q.delete();
                out_cnt = 0;
                last_due = 0;
                prev_stall = 1'b0;
                avm_waitrequest = 1'b0;
                avm_readdatavalid = 1'b0;
            end else begin
                ws = wait_en ? int'($urandom_range(0, 1)) : 0;
                if (prev_stall && (avm_write !== pw || avm_read !== pr ||
                    avm_address !== pa || (avm_write && avm_writedata !== pd)))
                    stab_err++;
                if (avm_write && avm_read) both_err++;
                if (avm_write && ws == 0) begin
                    mem[avm_address] = avm_writedata;
                    n_wr++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                end
                if (avm_read && ws == 0) begin
                    due = cyc + int'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    q.push_back('{addr: avm_address, due: due});
                    n_rd++;
                    out_cnt++;
                end
                if (q.size() > 0 && q[0].due <= cyc) begin
                    rd = mem.exists(q[0].addr) ? mem[q[0].addr] : '0;
                    if (corrupt.exists(q[0].addr)) rd[3] = ~rd[3];
                    avm_readdata = rd;
                    avm_readdatavalid = 1'b1;
                    void'(q.pop_front());
                    out_cnt--;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                if (out_cnt > max_out) max_out = out_cnt;
                prev_stall = (avm_write || avm_read) && ws != 0;
                pw = avm_write;
                pr = avm_read;
                pa = avm_address;
                pd = avm_writedata;
                avm_waitrequest = (ws != 0);
            end
        end
    end

    initial begin
        bit reached;
        mem_rst = 1'b1;
        cal_success = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        seed = '0;
        repeat (3) @(negedge mem_clk);

        // Reset values
        check("rst_write", 512'(avm_write), 512'd0);
        check("rst_read", 512'(avm_read), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_pass", 512'(pass), 512'd0);
        check("rst_errcnt", 512'(err_count), 512'd0);
        check("rst_byteen", 512'(avm_byteenable), 512'hFFFF_FFFF_FFFF_FFFF);
        check("rst_burst", 512'(avm_burstcount), 512'd1);
        mem_rst = 1'b0;

        // 1: ideal memory, base 0x100, 64 words
        clear_counts();
        base_addr = 27'h100; num_words = 27'd64; seed = 32'hA5A5A5A5;
        pulse_start();
        check("t1_busy", 512'(busy), 512'd1);
        wait_done("t1_done", 2000);
        check("t1_pass", 512'(pass), 512'd1);
        check("t1_err", 512'(err_count), 512'd0);
        check("t1_busy_low", 512'(busy), 512'd0);
        check("t1_nwr", 512'(n_wr), 512'd64);
        check("t1_nrd", 512'(n_rd), 512'd64);
        check("t1_wr_span", 512'(last_wr_cyc - first_wr_cyc), 512'd63);
        check("t1_word100", mem[27'h100], {16{32'hA5A5A4A5}});
        check("t1_word13f", mem[27'h13F], {16{32'hA5A5A49A}});

        // 2: random stalls and latency, 1000 words
        clear_counts();
        wait_en = 1'b1; lat_min = 5; lat_max = 40;
        base_addr = 27'h2000; num_words = 27'd1000; seed = 32'h1234_5678;
        pulse_start();
        wait_done("t2_done", 20000);
        check("t2_pass", 512'(pass), 512'd1);
        check("t2_err", 512'(err_count), 512'd0);
        check("t2_nrd", 512'(n_rd), 512'd1000);
        check("t2_stable", 512'(stab_err), 512'd0);
        check("t2_max_out_le32", 512'(max_out <= 32), 512'd1);
        check("t2_no_wr_rd", 512'(both_err), 512'd0);

        // 3: two corrupted words
        clear_counts();
        wait_en = 1'b0; lat_min = 3; lat_max = 3;
        corrupt[27'h105] = 1'b1;
        corrupt[27'h1FF] = 1'b1;
        base_addr = 27'h100; num_words = 27'd256; seed = 32'hCAFE_F00D;
        pulse_start();
        wait_done("t3_done", 3000);
        check("t3_err", 512'(err_count), 512'd2);
        check("t3_first", 512'(first_err_addr), 512'h105);
        check("t3_pass", 512'(pass), 512'd0);
        corrupt.delete();

        // 4: empty run
        clear_counts();
        num_words = 27'd0;
        pulse_start();
        check("t4_done", 512'(done), 512'd1);
        check("t4_pass", 512'(pass), 512'd1);
        check("t4_err_clr", 512'(err_count), 512'd0);
        repeat (3) @(negedge mem_clk);
        check("t4_nwr", 512'(n_wr), 512'd0);
        check("t4_nrd", 512'(n_rd), 512'd0);

        // 5: address wrap
        clear_counts();
        base_addr = 27'h7FFFFFC; num_words = 27'd8; seed = 32'h0F0F0F0F;
        pulse_start();
        wait_done("t5_done", 500);
        check("t5_pass", 512'(pass), 512'd1);
        check("t5_word0", mem[27'h0], {16{32'h0F0F0F0F}});
        check("t5_word3", mem[27'h3], {16{32'h0F0F0F0C}});
        check("t5_wordtop", mem[27'h7FFFFFF], {16{32'h08F0F0F0}});

        // 6: reset while reads are outstanding
        clear_counts();
        lat_min = 30; lat_max = 30;
        base_addr = 27'h3000; num_words = 27'd64; seed = 32'h5555_AAAA;
        pulse_start();
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (out_cnt >= 10) begin
                reached = 1'b1;
                break;
            end
            @(negedge mem_clk);
        end
        check("t6_outstanding10", 512'(reached), 512'd1);
        mem_rst = 1'b1;
        @(negedge mem_clk);
        check("t6_rst_read", 512'(avm_read), 512'd0);
        check("t6_rst_busy", 512'(busy), 512'd0);
        check("t6_rst_done", 512'(done), 512'd0);
        check("t6_rst_addr", 512'(avm_address), 512'd0);
        check("t6_rst_wdata", avm_writedata, 512'd0);
        mem_rst = 1'b0;
        lat_min = 2; lat_max = 2;

        // start without calibration is ignored
        cal_success = 1'b0;
        num_words = 27'd5;
        pulse_start();
        @(negedge mem_clk);
        check("t6_nocal_busy", 512'(busy), 512'd0);
        check("t6_nocal_write", 512'(avm_write), 512'd0);
        check("t6_nocal_done", 512'(done), 512'd0);
        cal_success = 1'b1;

        // start while busy is ignored
        clear_counts();
        base_addr = 27'h400; num_words = 27'd16; seed = 32'h0BAD_BEEF;
        pulse_start();
        repeat (3) @(negedge mem_clk);
        base_addr = 27'h800; num_words = 27'd4;
        pulse_start();
        check("t7_still_busy", 512'(busy), 512'd1);
        wait_done("t7_done", 500);
        check("t7_pass", 512'(pass), 512'd1);
        check("t7_nwr", 512'(n_wr), 512'd16);
        check("t7_no_restart", 512'(mem.exists(27'h800)), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
